// File: rtl/pspin_her_gen_mc.sv
// pspin_her_gen_mc: multi-channel Handler Execution Request generator.
// Round-robin arbitration over NUM_CH ingress DMA completion channels.
// Tag decode into {msgid, is_eom, ctx_id}, per-context metadata attach,
// and a two-entry skid buffer so her_ready never reaches gen_ready.
// Optional feature macro: PSPIN_HER_GEN_MC_STATS_EN (saturating HER counters).
module pspin_her_gen_mc #(
  parameter int NUM_CH         = 2,
  parameter int NUM_CTX        = 4,
  parameter int C_MSGID_WIDTH  = 10,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int LEN_WIDTH      = 20,
  parameter int TAG_WIDTH      = 32,
  parameter int META_WIDTH     = 64,
  parameter int XFER_MAX       = 1024,
  localparam int CTX_ID_WIDTH  = $clog2(NUM_CTX)
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              conf_valid,
  input  logic [NUM_CTX-1:0]                conf_ctx_enabled,
  input  logic [NUM_CTX*META_WIDTH-1:0]     conf_meta,
  input  logic [NUM_CH-1:0]                 gen_valid,
  output logic [NUM_CH-1:0]                 gen_ready,
  input  logic [NUM_CH*AXI_ADDR_WIDTH-1:0]  gen_addr,
  input  logic [NUM_CH*LEN_WIDTH-1:0]       gen_len,
  input  logic [NUM_CH*TAG_WIDTH-1:0]       gen_tag,
  output logic                              her_valid,
  input  logic                              her_ready,
  output logic [C_MSGID_WIDTH-1:0]          her_msgid,
  output logic                              her_is_eom,
  output logic [AXI_ADDR_WIDTH-1:0]         her_addr,
  output logic [AXI_ADDR_WIDTH-1:0]         her_size,
  output logic [AXI_ADDR_WIDTH-1:0]         her_xfer_size,
  output logic [CTX_ID_WIDTH-1:0]           her_ctx_id,
  output logic [META_WIDTH-1:0]             her_meta,
  output logic [31:0]                       stat_her_cnt,
  output logic [31:0]                       stat_dflt_cnt
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  if (TAG_WIDTH < C_MSGID_WIDTH + 1 + CTX_ID_WIDTH) begin : g_bad_tag_w
    $error("pspin_her_gen_mc: TAG_WIDTH too small for {msgid, is_eom, ctx_id}");
  end
  if (LEN_WIDTH > AXI_ADDR_WIDTH) begin : g_bad_len_w
    $error("pspin_her_gen_mc: LEN_WIDTH must not exceed AXI_ADDR_WIDTH");
  end

  typedef struct packed {
    logic [C_MSGID_WIDTH-1:0]  msgid;
    logic                      is_eom;
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic [AXI_ADDR_WIDTH-1:0] size;
    logic [AXI_ADDR_WIDTH-1:0] xfer;
    logic [CTX_ID_WIDTH-1:0]   ctx_id;
    logic [META_WIDTH-1:0]     meta;
    logic                      dflt;
  } her_t;

  // L1 transfer size: completion length clamped to XFER_MAX.
  function automatic logic [AXI_ADDR_WIDTH-1:0] clamp_xfer(input logic [LEN_WIDTH-1:0] len);
    logic [AXI_ADDR_WIDTH-1:0] len_z;
    len_z = AXI_ADDR_WIDTH'(len);
    if (len_z > AXI_ADDR_WIDTH'(XFER_MAX)) begin
      return AXI_ADDR_WIDTH'(XFER_MAX);
    end
    return len_z;
  endfunction

  logic [NUM_CTX-1:0]            ctx_en_q;
  logic [NUM_CTX*META_WIDTH-1:0] meta_q;
  logic [PTR_W-1:0]              ptr_q;
  logic [PTR_W-1:0]              gnt_idx;
  logic                          found;
  logic                          can_acc;
  logic                          accept;
  logic                          pop;

  logic [1:0] state_q;
  logic [1:0] state_nxt;
  logic       load_head;
  logic       head_from_skid;
  logic       load_skid;

  logic [CTX_ID_WIDTH-1:0]  tag_ctx;
  logic [CTX_ID_WIDTH-1:0]  use_ctx;
  her_t                     ent_p0;
  her_t                     head_p1;
  her_t                     skid_p1;
  logic                     vld_p1;

  // Config store: every enable and metadata slice is replaced on conf_valid.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ctx_en_q <= '0;
      meta_q   <= '0;
    end else if (conf_valid) begin
      ctx_en_q <= conf_ctx_enabled;
      meta_q   <= conf_meta;
    end
  end

  // Round-robin search for the first valid channel at or after the pointer.
  always_comb begin
    int c;
    found   = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      c = int'(ptr_q) + i;
      if (c >= NUM_CH) c = c - NUM_CH;
      if (!found && gen_valid[c]) begin
        found   = 1'b1;
        gnt_idx = PTR_W'(c);
      end
    end
  end

  // Grant needs context 0 enabled and a free skid slot; her_ready is not involved.
  assign can_acc   = ctx_en_q[0] && (state_q != ST_TWO);
  assign accept    = can_acc && found;
  assign gen_ready = accept ? (NUM_CH'(1) << gnt_idx) : '0;
  assign pop       = vld_p1 && her_ready;

  // ---- stage p0: decode the granted completion into a HER entry ----
  assign tag_ctx = gen_tag[gnt_idx*TAG_WIDTH +: CTX_ID_WIDTH];
  assign use_ctx = ctx_en_q[tag_ctx] ? tag_ctx : '0;

  // Build the HER from the granted channel using the config seen this cycle.
  always_comb begin
    ent_p0        = '0;
    ent_p0.msgid  = gen_tag[gnt_idx*TAG_WIDTH + CTX_ID_WIDTH + 1 +: C_MSGID_WIDTH];
    ent_p0.is_eom = gen_tag[gnt_idx*TAG_WIDTH + CTX_ID_WIDTH];
    ent_p0.addr   = gen_addr[gnt_idx*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
    ent_p0.size   = AXI_ADDR_WIDTH'(gen_len[gnt_idx*LEN_WIDTH +: LEN_WIDTH]);
    ent_p0.xfer   = clamp_xfer(gen_len[gnt_idx*LEN_WIDTH +: LEN_WIDTH]);
    ent_p0.ctx_id = use_ctx;
    ent_p0.meta   = meta_q[use_ctx*META_WIDTH +: META_WIDTH];
    ent_p0.dflt   = !ctx_en_q[tag_ctx];
  end

  // Skid buffer next-state: head is always the oldest entry, skid the newer one.
  always_comb begin
    state_nxt      = state_q;
    load_head      = 1'b0;
    head_from_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_nxt = ST_ONE;
          load_head = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && !pop) begin
          state_nxt = ST_TWO;
          load_skid = 1'b1;
        end else if (!accept && pop) begin
          state_nxt = ST_EMPTY;
        end else if (accept && pop) begin
          load_head = 1'b1;
        end
      end
      ST_TWO: begin
        if (pop) begin
          state_nxt      = ST_ONE;
          head_from_skid = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  // ---- stage p1: skid buffer registers drive the HER port directly ----
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_EMPTY;
      vld_p1  <= 1'b0;
      head_p1 <= '0;
      skid_p1 <= '0;
    end else begin
      state_q <= state_nxt;
      vld_p1  <= (state_nxt != ST_EMPTY);
      if (load_head) begin
        head_p1 <= ent_p0;
      end else if (head_from_skid) begin
        head_p1 <= skid_p1;
      end
      if (load_skid) begin
        skid_p1 <= ent_p0;
      end
    end
  end

  // Priority pointer advances past the granted channel on each handshake.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr_q <= '0;
    end else if (accept) begin
      ptr_q <= (gnt_idx == PTR_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  assign her_valid     = vld_p1;
  assign her_msgid     = head_p1.msgid;
  assign her_is_eom    = head_p1.is_eom;
  assign her_addr      = head_p1.addr;
  assign her_size      = head_p1.size;
  assign her_xfer_size = head_p1.xfer;
  assign her_ctx_id    = head_p1.ctx_id;
  assign her_meta      = head_p1.meta;

`ifdef PSPIN_HER_GEN_MC_STATS_EN
  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] her_cnt_q;
  logic [31:0] dflt_cnt_q;

  // Count HER-port handshakes, and separately those redirected to context 0.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      her_cnt_q  <= '0;
      dflt_cnt_q <= '0;
    end else if (pop) begin
      her_cnt_q <= sat_inc(her_cnt_q);
      if (head_p1.dflt) begin
        dflt_cnt_q <= sat_inc(dflt_cnt_q);
      end
    end
  end

  assign stat_her_cnt  = her_cnt_q;
  assign stat_dflt_cnt = dflt_cnt_q;
`else
  assign stat_her_cnt  = 32'd0;
  assign stat_dflt_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pspin_her_gen_mc.sv
// Directed self-checking bench for pspin_her_gen_mc (NUM_CH=2, NUM_CTX=4).
// Counter expectations follow PSPIN_HER_GEN_MC_STATS_EN (zero when undefined).
module tb_pspin_her_gen_mc;
  localparam int NCH = 2;
  localparam int NCTX = 4;
  localparam int MW = 10;
  localparam int AW = 32;
  localparam int LW = 20;
  localparam int TW = 32;
  localparam int MTW = 64;

`ifdef PSPIN_HER_GEN_MC_STATS_EN
  localparam logic [31:0] STATS = 32'd1;
`else
  localparam logic [31:0] STATS = 32'd0;
`endif

  localparam logic [63:0] M0  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] M1A = 64'hAAAA_0001_0000_0001;
  localparam logic [63:0] M1B = 64'hBBBB_0002_0000_0002;
  localparam logic [63:0] M2  = 64'h2222_3333_4444_5555;
  localparam logic [63:0] M3  = 64'h3333_4444_5555_6666;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic                 conf_valid;
  logic [NCTX-1:0]      conf_ctx_enabled;
  logic [NCTX*MTW-1:0]  conf_meta;
  logic [NCH-1:0]       gen_valid;
  logic [NCH-1:0]       gen_ready;
  logic [NCH*AW-1:0]    gen_addr;
  logic [NCH*LW-1:0]    gen_len;
  logic [NCH*TW-1:0]    gen_tag;
  logic                 her_valid;
  logic                 her_ready;
  logic [MW-1:0]        her_msgid;
  logic                 her_is_eom;
  logic [AW-1:0]        her_addr;
  logic [AW-1:0]        her_size;
  logic [AW-1:0]        her_xfer_size;
  logic [1:0]           her_ctx_id;
  logic [MTW-1:0]       her_meta;
  logic [31:0]          stat_her_cnt;
  logic [31:0]          stat_dflt_cnt;

  int checks = 0;
  int failures = 0;
  int c0;
  int c1;

  pspin_her_gen_mc #(
    .NUM_CH(NCH), .NUM_CTX(NCTX), .C_MSGID_WIDTH(MW), .AXI_ADDR_WIDTH(AW),
    .LEN_WIDTH(LW), .TAG_WIDTH(TW), .META_WIDTH(MTW), .XFER_MAX(1024)
  ) dut (
    .clk(clk), .rstn(rstn),
    .conf_valid(conf_valid), .conf_ctx_enabled(conf_ctx_enabled), .conf_meta(conf_meta),
    .gen_valid(gen_valid), .gen_ready(gen_ready), .gen_addr(gen_addr),
    .gen_len(gen_len), .gen_tag(gen_tag),
    .her_valid(her_valid), .her_ready(her_ready), .her_msgid(her_msgid),
    .her_is_eom(her_is_eom), .her_addr(her_addr), .her_size(her_size),
    .her_xfer_size(her_xfer_size), .her_ctx_id(her_ctx_id), .her_meta(her_meta),
    .stat_her_cnt(stat_her_cnt), .stat_dflt_cnt(stat_dflt_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input int ch, input logic [31:0] tag, input logic [31:0] addr,
                       input logic [19:0] len);
    gen_tag[ch*TW +: TW]  = tag;
    gen_addr[ch*AW +: AW] = addr;
    gen_len[ch*LW +: LW]  = len;
  endtask

  function automatic logic [31:0] mk_tag(input int msgid, input int eom, input int ctx);
    return 32'((msgid << 3) | (eom << 2) | ctx);
  endfunction

  task automatic check_stats(input string tag, input logic [31:0] her_n, input logic [31:0] dflt_n);
    check({tag, "_her_cnt"}, 64'(stat_her_cnt), 64'(her_n * STATS));
    check({tag, "_dflt_cnt"}, 64'(stat_dflt_cnt), 64'(dflt_n * STATS));
  endtask

  initial begin
    rstn = 1'b0;
    conf_valid = 1'b0;
    conf_ctx_enabled = '0;
    conf_meta = {M3, M2, M1A, M0};
    gen_valid = '0;
    gen_addr = '0;
    gen_len = '0;
    gen_tag = '0;
    her_ready = 1'b0;
    repeat (2) step();

    // reset state
    check("rst_her_valid", 64'(her_valid), 64'd0);
    check("rst_gen_ready", 64'(gen_ready), 64'd0);
    check("rst_her_addr", 64'(her_addr), 64'd0);
    check("rst_her_meta", her_meta, 64'd0);
    check_stats("rst", 0, 0);
    rstn = 1'b1;
    step();

    // gated until context 0 is enabled
    offer(0, mk_tag(7, 0, 1), 32'h1000, 20'd100);
    gen_valid = 2'b01;
    #1 check("gate_ready0", 64'(gen_ready), 64'd0);
    step();
    check("gate_ready1", 64'(gen_ready), 64'd0);
    conf_ctx_enabled = 4'b0011;
    conf_valid = 1'b1;
    #1 check("gate_ready2", 64'(gen_ready), 64'd0);
    step();
    conf_valid = 1'b0;
    #1 check("gate_open", 64'(gen_ready), 64'b01);
    step();
    gen_valid = 2'b00;
    check("t1_valid", 64'(her_valid), 64'd1);
    check("t1_ctx", 64'(her_ctx_id), 64'd1);
    check("t1_meta", her_meta, M1A);
    check("t1_msgid", 64'(her_msgid), 64'd7);
    check("t1_addr", 64'(her_addr), 64'h1000);
    check("t1_xfer", 64'(her_xfer_size), 64'd100);
    her_ready = 1'b1;
    step();
    her_ready = 1'b0;
    check("t1_drained", 64'(her_valid), 64'd0);
    check_stats("t1", 1, 0);

    // redirect to context 0, length above the transfer cap
    conf_ctx_enabled = 4'b0001;
    conf_valid = 1'b1;
    step();
    conf_valid = 1'b0;
    offer(0, mk_tag(5, 1, 2), 32'h2000, 20'd2000);
    gen_valid = 2'b01;
    #1 check("t2_ready", 64'(gen_ready), 64'b01);
    step();
    gen_valid = 2'b00;
    check("t2_ctx", 64'(her_ctx_id), 64'd0);
    check("t2_msgid", 64'(her_msgid), 64'd5);
    check("t2_eom", 64'(her_is_eom), 64'd1);
    check("t2_size", 64'(her_size), 64'd2000);
    check("t2_xfer", 64'(her_xfer_size), 64'd1024);
    check("t2_meta", her_meta, M0);
    her_ready = 1'b1;
    step();
    her_ready = 1'b0;
    check_stats("t2", 2, 1);

    // round robin, pointer now at ch1 after the ch0 grant above
    offer(0, mk_tag(1, 0, 0), 32'h100, 20'd64);
    offer(1, mk_tag(2, 0, 0), 32'h200, 20'd64);
    gen_valid = 2'b11;
    her_ready = 1'b1;
    c0 = 0;
    c1 = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      check("rr_valid", 64'(her_valid), 64'd1);
      check("rr_addr", 64'(her_addr), (k % 2 == 0) ? 64'h200 : 64'h100);
      check("rr_onehot", 64'($countones(gen_ready)), 64'd1);
      if (her_addr == 32'h100) c0++;
      else if (her_addr == 32'h200) c1++;
    end
    gen_valid = 2'b00;
    step();
    her_ready = 1'b0;
    check("rr_drained", 64'(her_valid), 64'd0);
    check("rr_ch0_cnt", 64'(c0), 64'd4);
    check("rr_ch1_cnt", 64'(c1), 64'd4);
    check_stats("rr", 10, 1);

    // backpressure fills the skid buffer with two entries
    offer(0, mk_tag(20, 0, 0), 32'h300, 20'd10);
    offer(1, mk_tag(21, 0, 0), 32'h400, 20'd11);
    gen_valid = 2'b11;
    #1 check("bp_ready_a", 64'(gen_ready), 64'b10);
    step();
    #1 check("bp_ready_b", 64'(gen_ready), 64'b01);
    step();
    gen_valid = 2'b10;
    offer(1, mk_tag(22, 0, 0), 32'h500, 20'd12);
    #1 check("bp_full", 64'(gen_ready), 64'd0);
    check("bp_head_addr", 64'(her_addr), 64'h400);
    step();
    check("bp_full_hold", 64'(gen_ready), 64'd0);
    check("bp_head_msgid", 64'(her_msgid), 64'd21);
    check("bp_head_size", 64'(her_size), 64'd11);
    her_ready = 1'b1;
    #1 check("bp_no_comb_path", 64'(gen_ready), 64'd0);
    step();
    check("bp_d2_addr", 64'(her_addr), 64'h300);
    check("bp_d2_msgid", 64'(her_msgid), 64'd20);
    #1 check("bp_third_ready", 64'(gen_ready), 64'b10);
    step();
    gen_valid = 2'b00;
    check("bp_d3_valid", 64'(her_valid), 64'd1);
    check("bp_d3_addr", 64'(her_addr), 64'h500);
    check("bp_d3_msgid", 64'(her_msgid), 64'd22);
    step();
    her_ready = 1'b0;
    check("bp_drained", 64'(her_valid), 64'd0);
    check_stats("bp", 13, 1);

    // config change in the accept cycle takes effect afterwards
    conf_ctx_enabled = 4'b0011;
    conf_meta = {M3, M2, M1A, M0};
    conf_valid = 1'b1;
    step();
    offer(0, mk_tag(30, 0, 1), 32'h600, 20'd8);
    gen_valid = 2'b01;
    conf_meta = {M3, M2, M1B, M0};
    #1 check("cc_ready", 64'(gen_ready), 64'b01);
    step();
    conf_valid = 1'b0;
    check("cc_meta_old", her_meta, M1A);
    check("cc_ctx", 64'(her_ctx_id), 64'd1);
    offer(0, mk_tag(31, 0, 1), 32'h700, 20'd8);
    her_ready = 1'b1;
    step();
    gen_valid = 2'b00;
    check("cc_meta_new", her_meta, M1B);
    check("cc_msgid", 64'(her_msgid), 64'd31);
    step();
    her_ready = 1'b0;
    check("cc_drained", 64'(her_valid), 64'd0);
    check_stats("cc", 15, 1);

    // reset while two HERs are buffered
    offer(0, mk_tag(40, 0, 0), 32'h800, 20'd4);
    offer(1, mk_tag(41, 0, 0), 32'h900, 20'd4);
    gen_valid = 2'b11;
    step();
    step();
    check("rs_full_valid", 64'(her_valid), 64'd1);
    check("rs_full_head", 64'(her_addr), 64'h900);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    check("rs_her_valid", 64'(her_valid), 64'd0);
    check("rs_her_addr", 64'(her_addr), 64'd0);
    check_stats("rs", 0, 0);
    #1 check("rs_ctx_disabled", 64'(gen_ready), 64'd0);
    conf_ctx_enabled = 4'b0001;
    conf_valid = 1'b1;
    step();
    conf_valid = 1'b0;
    #1 check("rs_ptr_ch0", 64'(gen_ready), 64'b01);
    gen_valid = 2'b00;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
